// File: rtl/pp_buf_pkg.sv
// Shared definitions for the ping-pong buffer: reader FSM encoding,
// frame counter width and bank index constants.
package pp_buf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int FRAME_CNT_W = 16;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/pp_buf_reader.sv
// Read side of the ping-pong buffer. Drains the current bank once the writer
// marks it full, streams its DEPTH words as one AXI4-Stream frame with TLAST on
// the final word, then hands the bank back with a one-cycle done pulse and
// moves on to the other bank. Banks are served strictly 0, 1, 0, ...
module pp_buf_reader
  import pp_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDRW      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             bank_full,
  output logic [1:0]             bank_done,
  output logic                   rd_en,
  output logic                   rd_bank,
  output logic [ADDRW-1:0]       rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  // One extra bit so the issued counter can reach DEPTH itself.
  localparam logic [ADDRW:0]   ISSUE_MAX = (ADDRW + 1)'(DEPTH);
  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

  state_t         state;
  logic           cur_bank;
  logic [ADDRW:0] issued;
  logic           load;
  logic           last_accept;

  // The output register may take a new word whenever it is empty or being
  // emptied this cycle; that alone gives full rate without a skid buffer.
  // NOTE: rd_en must be combinational because the RAM returns rd_data in the
  // same cycle, so the word is captured on the very edge that consumes it.
  assign load        = (state == STREAM) && (!m_axis_tvalid || m_axis_tready) &&
                       (issued < ISSUE_MAX);
  assign last_accept = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  // Read-port and status decode.
  assign rd_en   = load;
  assign rd_bank = cur_bank;
  assign busy    = (state != IDLE);

  // Reader FSM, read address/issue counters and the registered stream output.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others, which the handshake logic relies on.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: tdata is reset too; it is a single register, not a memory, and a
      // defined value after reset keeps downstream X-free.
      state         <= IDLE;
      cur_bank      <= BANK0;
      issued        <= '0;
      rd_addr       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      bank_done     <= '0;
      frame_cnt     <= '0;
    end else begin
      bank_done <= '0;
      case (state)
        IDLE: begin
          // Only the current bank may start a frame; the other one waits.
          if (en && bank_full[cur_bank]) begin
            state   <= STREAM;
            rd_addr <= '0;
            issued  <= '0;
          end
        end

        STREAM: begin
          if (load) begin
            m_axis_tdata  <= rd_data;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (rd_addr == LAST_ADDR);
            rd_addr       <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
            issued        <= issued + 1'b1;
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
          end
          // The final beat can never coincide with a load: all words issued.
          if (last_accept) begin
            m_axis_tvalid       <= 1'b0;
            m_axis_tlast        <= 1'b0;
            bank_done[cur_bank] <= 1'b1;
            state               <= RELEASE;
          end
        end

        RELEASE: begin
          // bank_done is already high this cycle; flip to the other bank.
          frame_cnt <= frame_cnt + 1'b1;
          cur_bank  <= ~cur_bank;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pp_buf_reader.md
Name: pp_buf_reader

Overview:
- Read-side controller for the ping-pong buffer.
- Drains whichever bank the writer has marked full, strictly alternating bank 0, 1, 0, ….
- Streams each bank's DEPTH words out as one AXI4-Stream frame, with TLAST on the final word.
- Sits between the two dp_ram banks' read ports (enb/addrb/dob) and the downstream DMA/FFT stream consumer.
- Returns each bank to the writer with a one-cycle done pulse once the frame has been accepted.

Parameters:
- DATA_WIDTH, 32, word width; equals the RAM dob width.
- DEPTH, 16, words per bank; must equal 2**ADDRW.
- ADDRW, 4, RAM address width.

Ports:
- clk  in  1  single clock, shared with the RAM banks and writer.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start permission; sampled only in IDLE.
- bank_full  in  2  level per bank from the writer; held until the matching bank_done pulse.
- bank_done  out  2  one-cycle pulse per bank; the bank has been fully read and is free.
- rd_en  out  1  read enable to the selected bank (drives enb).
- rd_bank  out  1  bank select for the RAM read mux.
- rd_addr  out  ADDRW  read address (drives addrb).
- rd_data  in  DATA_WIDTH  combinational RAM read data; valid in the same cycle as rd_en.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last word of the bank.
- busy  out  1  high in any state other than IDLE.
- frame_cnt  out  16  count of completed frames; wraps at 65535 to 0.

Behaviour:
- Reset values:
  - Outputs tvalid, tlast, bank_done, rd_en, busy, rd_addr, frame_cnt are all 0. tdata resets to 0.
  - Internal cur_bank=0, state=IDLE.
  - Reset in any state aborts the frame: no done pulse, no tlast, partial frame discarded.
- rd_bank always equals cur_bank.
- States: IDLE, STREAM, RELEASE.
- IDLE:
  - Go to STREAM when en=1 and bank_full[cur_bank]=1; clear rd_addr and the issued counter.
  - bank_full of the non-current bank is ignored, so alternation is strict.
- STREAM:
  - Output register load condition: load = (!m_axis_tvalid || m_axis_tready) && (issued < DEPTH).
  - rd_en = load, combinationally. rd_en is 0 outside STREAM.
  - On load, all at the clock edge:
    - tdata <= rd_data; tvalid <= 1.
    - tlast <= (rd_addr == DEPTH-1).
    - rd_addr increments; it wraps to 0 after DEPTH-1. issued increments.
  - If tready=1 and no load happens, tvalid <= 0.
  - While tvalid=1 and tready=0, tdata and tlast are held stable. tvalid is never withdrawn without a handshake.
  - When the beat with tlast=1 is accepted (tvalid&tready&tlast): tvalid <= 0, tlast <= 0, go to RELEASE.
- RELEASE (one cycle):
  - bank_done[cur_bank]=1.
  - frame_cnt increments.
  - cur_bank toggles.
  - Go to IDLE.
- Latency:
  - bank_full rises at cycle N with en=1 → state=STREAM at N+1, rd_en=1 with addr 0 at N+1, first tvalid at N+2.
  - With tready held at 1: DEPTH consecutive valid beats, tlast at beat N+1+DEPTH.
  - bank_done pulses at N+2+DEPTH.
  - Earliest next-frame tvalid is 3 cycles after the last beat (RELEASE → IDLE → STREAM → valid).
- Throughput: 1 word/cycle under continuous tready. The registered output gives full rate without a skid buffer, because load is permitted whenever the register is being emptied.
- Boundaries:
  - Both banks full: serve cur_bank first, then the other without waiting for en to toggle; en=1 is still required in IDLE.
  - en dropping mid-frame has no effect; the frame completes.
  - bank_full[cur_bank] dropping mid-frame is a protocol violation. It is ignored and the frame completes.
  - DEPTH=1: the single word carries tlast=1.
- busy: 1 in STREAM and RELEASE.

Decomposition:
- Shared package pp_buf_pkg holds:
  - the state encoding (IDLE=2'd0, STREAM=2'd1, RELEASE=2'd2);
  - FRAME_CNT_W=16;
  - the bank index constants.
- No sub-module. FSM, address/issued counters and output register live in one module of about 150–200 lines. The writer side already exists separately.

Test Plan:
- Basic frame: reset; en=1; bank_full=2'b01 at cycle 10; RAM bank0 holds word i = 0x100+i; tready=1.
  - Required: tvalid cycles 12..27 with data 0x100..0x10F; tlast only at cycle 27; bank_done=2'b01 at cycle 28; frame_cnt=1; bank_full=2'b10 then serves bank 1.
- Backpressure: same setup; tready toggles 1,0,0,1 repeating.
  - Required: exactly 16 accepted beats in order 0x100..0x10F, no duplicates or drops.
  - While tready=0, tdata/tlast stay stable and tvalid stays 1.
  - rd_en is never high while tvalid=1 and tready=0.
- Alternation: bank_full=2'b11 held.
  - Required: bank0 frame then bank1 frame; bank_done sequence 01 then 10.
  - Gap of 3 cycles between bank0 tlast and first bank1 tvalid; frame_cnt=2.
- Wrong-bank full: cur_bank=0, bank_full=2'b10 only for 50 cycles.
  - Required: tvalid stays 0, busy=0, rd_en=0.
  - Raising bank_full[0] then starts streaming bank 0.
- Reset mid-frame: assert rst for 1 cycle after beat 5 is accepted.
  - Required: next cycle tvalid=0, tlast=0, bank_done=0, frame_cnt=0.
  - The next frame starts from bank 0, addr 0.
- en gating: bank_full=2'b01 with en=0 for 20 cycles → no rd_en, no tvalid. Setting en=1 → first tvalid 2 cycles later.
